// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default sizes, pointer type and
// Gray/binary conversion helpers used by both the read and write controllers.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int PTR_WIDTH = $clog2(DEPTH_DEF);

  typedef logic [PTR_WIDTH:0] ptr_t;

  // Helpers work on a 32-bit container so any pointer width up to 32 fits;
  // callers zero-extend in and truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock.
module fifo_ptr_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: synchronises the write pointer, issues RAM reads
// and presents the words as a valid/ready stream through a 2-entry buffer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [PTR_WIDTH:0]   wptr_gray_async,
  output logic [PTR_WIDTH:0]   rptr_gray,
  output logic                 mem_rd_en,
  output logic [PTR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]     mem_rd_data,
  output logic                 empty,
  output logic [PTR_WIDTH:0]   rd_level,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef logic [PTR_WIDTH:0] lptr_t;

  lptr_t            wptr_sync;
  lptr_t            wptr_sync_bin;
  lptr_t            rptr_bin_q, rptr_bin_d;
  lptr_t            rptr_gray_q, rptr_gray_d;
  logic             rd_flight_q, rd_flight_d;
  logic [1:0]       buf_count_q, buf_count_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [2:0]       credit;
  logic             issue;
  logic             push;
  logic             pop;

  fifo_ptr_sync #(.W(PTR_WIDTH + 1)) u_wptr_sync (
    .clk   (r_clk),
    .rst   (r_rst),
    .d_in  (wptr_gray_async),
    .q_out (wptr_sync)
  );

  assign wptr_sync_bin = lptr_t'(gray2bin(32'(wptr_sync)));
  assign empty         = (rptr_gray_q == wptr_sync);
  assign rd_level      = wptr_sync_bin - rptr_bin_q;

  assign out_valid = (buf_count_q != 2'd0);
  assign data_out  = buf0_q;
  assign pop       = out_valid && out_ready;
  assign push      = rd_flight_q;

  // A slot freed by this cycle's pop counts as available, which is what lets
  // the loop sustain one word per clock without ever exceeding two outstanding.
  always_comb begin
    credit = {1'b0, buf_count_q} + {2'b00, rd_flight_q} - {2'b00, pop};
    issue  = !empty && (credit < 3'd2);
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rptr_bin_q[PTR_WIDTH-1:0];
  assign rptr_gray   = rptr_gray_q;

  always_comb begin
    rptr_bin_d  = rptr_bin_q;
    rptr_gray_d = rptr_gray_q;
    rd_flight_d = issue;
    if (issue) begin
      rptr_bin_d  = rptr_bin_q + lptr_t'(1);
      rptr_gray_d = lptr_t'(bin2gray(32'(rptr_bin_q + lptr_t'(1))));
    end
  end

  always_comb begin
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf_count_d = buf_count_q;
    case ({push, pop})
      2'b10: begin
        if (buf_count_q == 2'd0) buf0_d = mem_rd_data;
        else                     buf1_d = mem_rd_data;
        buf_count_d = buf_count_q + 2'd1;
      end
      2'b01: begin
        buf0_d      = buf1_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b11: begin
        if (buf_count_q == 2'd1) begin
          buf0_d = mem_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      rd_flight_q <= 1'b0;
      buf_count_q <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      rd_flight_q <= rd_flight_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 1-cycle-latency RAM.
module tb_fifo_rd_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic          r_clk;
  logic          r_rst;
  logic [PW:0]   wptr_gray_async;
  logic [PW:0]   rptr_gray;
  logic          mem_rd_en;
  logic [PW-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic          empty;
  logic [PW:0]   rd_level;
  logic [WIDTH-1:0] data_out;
  logic          out_valid;
  logic          out_ready;

  logic [WIDTH-1:0] ram [DEPTH];

  int n_cmp;
  int n_bad;

  fifo_rd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .r_clk           (r_clk),
    .r_rst           (r_rst),
    .wptr_gray_async (wptr_gray_async),
    .rptr_gray       (rptr_gray),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .empty           (empty),
    .rd_level        (rd_level),
    .data_out        (data_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    r_rst = 1'b1;
    wptr_gray_async = '0;
    for (int i = 0; i < cycles; i++) tick();
    r_rst = 1'b0;
  endtask

  initial begin
    int got;
    n_cmp = 0;
    n_bad = 0;
    out_ready = 1'b0;
    mem_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    // 1. reset
    r_rst = 1'b1;
    wptr_gray_async = '0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rden", 32'(mem_rd_en), 0);
    chk("rst_rptr", 32'(rptr_gray), 0);
    chk("rst_level", 32'(rd_level), 0);
    chk("rst_data", 32'(data_out), 0);
    r_rst = 1'b0;

    // 2. single word
    ram[0] = 8'hEA;
    wptr_gray_async = 4'b0001;
    tick();
    chk("sw_empty_e1", 32'(empty), 1);
    tick();
    chk("sw_rden_e2", 32'(mem_rd_en), 1);
    chk("sw_addr_e2", 32'(mem_rd_addr), 0);
    chk("sw_level_e2", 32'(rd_level), 1);
    tick();
    chk("sw_rptr_e3", 32'(rptr_gray), 4'b0001);
    chk("sw_valid_e3", 32'(out_valid), 0);
    chk("sw_rden_e3", 32'(mem_rd_en), 0);
    tick();
    chk("sw_valid_e4", 32'(out_valid), 1);
    chk("sw_data_e4", 32'(data_out), 8'hEA);
    out_ready = 1'b1;
    tick();
    chk("sw_valid_acc", 32'(out_valid), 0);
    chk("sw_empty_acc", 32'(empty), 1);
    chk("sw_rptr_acc", 32'(rptr_gray), 4'b0001);
    out_ready = 1'b0;

    // 3. full drain from a fresh pointer
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
    wptr_gray_async = 4'b1100;
    out_ready = 1'b1;
    tick(); tick();
    chk("fd_level", 32'(rd_level), 8);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        chk($sformatf("fd_rden_%0d", i), 32'(mem_rd_en), 1);
        chk($sformatf("fd_addr_%0d", i), 32'(mem_rd_addr), 32'(i));
      end
      if (i >= 2) begin
        chk($sformatf("fd_valid_%0d", i - 2), 32'(out_valid), 1);
        chk($sformatf("fd_data_%0d", i - 2), 32'(data_out), 32'(i - 2));
      end
      tick();
    end
    chk("fd_valid_end", 32'(out_valid), 0);
    chk("fd_empty_end", 32'(empty), 1);
    chk("fd_rptr_end", 32'(rptr_gray), 4'b1100);
    chk("fd_level_end", 32'(rd_level), 0);

    // 5. wrap-around continuing from pointer 8
    ram[0] = 8'hA0; ram[1] = 8'hA1; ram[2] = 8'hA2;
    wptr_gray_async = 4'b1110;
    tick(); tick();
    chk("wr_level", 32'(rd_level), 3);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        chk($sformatf("wr_rden_%0d", i), 32'(mem_rd_en), 1);
        chk($sformatf("wr_addr_%0d", i), 32'(mem_rd_addr), 32'(i));
      end
      if (i >= 2) begin
        chk($sformatf("wr_valid_%0d", i - 2), 32'(out_valid), 1);
        chk($sformatf("wr_data_%0d", i - 2), 32'(data_out), 32'(8'hA0 + i - 2));
      end
      tick();
    end
    chk("wr_valid_end", 32'(out_valid), 0);
    chk("wr_empty_end", 32'(empty), 1);
    chk("wr_rptr_end", 32'(rptr_gray), 4'b1110);

    // 4. backpressure
    out_ready = 1'b0;
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
    wptr_gray_async = 4'b1100;
    tick(); tick();
    chk("bp_rden_e2", 32'(mem_rd_en), 1);
    tick();
    chk("bp_rden_e3", 32'(mem_rd_en), 1);
    chk("bp_addr_e3", 32'(mem_rd_addr), 1);
    tick();
    chk("bp_rden_e4", 32'(mem_rd_en), 0);
    tick(); tick(); tick();
    chk("bp_rden_hold", 32'(mem_rd_en), 0);
    chk("bp_level_hold", 32'(rd_level), 6);
    chk("bp_valid_hold", 32'(out_valid), 1);
    chk("bp_data_hold", 32'(data_out), 0);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (out_valid) begin
        chk($sformatf("bp_data_%0d", got), 32'(data_out), 32'(got));
        got++;
      end
      tick();
    end
    chk("bp_beats", 32'(got), 8);
    tick(); tick();
    chk("bp_valid_end", 32'(out_valid), 0);
    chk("bp_empty_end", 32'(empty), 1);
    chk("bp_rptr_end", 32'(rptr_gray), 4'b1100);

    // 6. reset in the middle of a drain
    do_reset(2);
    wptr_gray_async = 4'b1100;
    out_ready = 1'b1;
    tick(); tick();
    tick(); tick(); tick(); tick();
    chk("mr_data_pre", 32'(data_out), 2);
    r_rst = 1'b1;
    wptr_gray_async = '0;
    tick();
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_rptr", 32'(rptr_gray), 0);
    r_rst = 1'b0;
    tick(); tick();
    chk("mr_empty", 32'(empty), 1);
    chk("mr_level", 32'(rd_level), 0);
    chk("mr_valid_late", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
